// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, loader sync byte and loader state encoding
package cpu_pkg;
  localparam int INS_W = 16;
  localparam int IMEM_ADDR_W = 8;
  localparam logic [7:0] LOADER_SYNC = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CSUM, FINISH} loader_state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader filling instruction memory while holding the CPU in reset
// LOADER_CHECKSUM_EN adds a trailing checksum byte and a functional sticky err
module imem_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0] SYNC = LOADER_SYNC,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INS_W-1:0]  wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  loader_state_e state;
  logic [8:0] cnt;
  logic [7:0] hi;
  logic take;
  assign take = in_valid && in_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  // wr_addr doubles as the word index; it is only cleared by LEN, never by the frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      in_ready <= 1'b1;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (take && in_data == SYNC) begin
          state <= LEN;
          cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          err_q <= 1'b0;
`endif
        end
        LEN: if (take) begin
          cnt <= {in_data == 8'h00, in_data};
          wr_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
          acc <= '0;
`endif
          state <= HI;
        end
        HI: if (take) begin
          hi <= in_data;
`ifdef LOADER_CHECKSUM_EN
          acc <= acc + in_data;
`endif
          state <= LO;
        end
        LO: if (take) begin
          wr_data <= {hi, in_data};
`ifdef LOADER_CHECKSUM_EN
          acc <= acc + in_data;
`endif
          wr_en <= 1'b1;
          in_ready <= 1'b0;
          state <= WR;
        end
        WR: begin
          wr_en <= 1'b0;
          wr_addr <= wr_addr + ADDR_W'(1);
          cnt <= cnt - 9'd1;
`ifdef LOADER_CHECKSUM_EN
          in_ready <= 1'b1;
          state <= (cnt == 9'd1) ? CSUM : HI;
`else
          in_ready <= (cnt != 9'd1);
          state <= (cnt == 9'd1) ? FINISH : HI;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (take) begin
          done <= (in_data == acc);
          cpu_hold <= (in_data != acc);
          err_q <= (in_data != acc);
          state <= IDLE;
        end
`else
        FINISH: begin
          done <= 1'b1;
          cpu_hold <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader in either checksum build
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, wr_en, cpu_hold, done, err;
  logic [7:0] wr_addr;
  logic [15:0] wr_data;
  int tests = 0, fails = 0, ndone = 0, nlow = 0, nrw = 0;
  logic [23:0] wq[$];
  logic [15:0] fw[$];
`ifdef LOADER_CHECKSUM_EN
  localparam int NL = 0;
`else
  localparam int NL = 1;
`endif

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (wr_en && in_ready) nrw++;
    if (!wr_en && !in_ready) nlow++;
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clear();
    wq.delete();
    ndone = 0;
    nlow = 0;
    nrw = 0;
  endtask

  task automatic frame(input string tag, input logic [7:0] len, input logic [7:0] cs, input int maxgap);
    send(8'hA5, $urandom_range(maxgap, 0));
    chk({tag, "_hold_sync"}, cpu_hold, 1);
    send(len, $urandom_range(maxgap, 0));
    foreach (fw[i]) begin
      send(fw[i][15:8], $urandom_range(maxgap, 0));
      send(fw[i][7:0], $urandom_range(maxgap, 0));
    end
`ifdef LOADER_CHECKSUM_EN
    send(cs, $urandom_range(maxgap, 0));
`endif
  endtask

  task automatic fin(input string tag);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold"}, cpu_hold, 0);
`else
    chk({tag, "_wr_after_lo"}, wr_en, 1);
    @(posedge clk); #1 chk({tag, "_done_early"}, done, 0);
    @(posedge clk); #1 chk({tag, "_done"}, done, 1);
    chk({tag, "_hold"}, cpu_hold, 0);
`endif
    @(posedge clk); #1 chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic chk_wr(input string tag, input int nd, input int nl);
    int bad = 0;
    repeat (4) @(negedge clk);
    chk({tag, "_nwr"}, wq.size(), fw.size());
    foreach (fw[i]) if (i >= wq.size() || wq[i] !== {i[7:0], fw[i]}) bad++;
    chk({tag, "_words"}, bad, 0);
    chk({tag, "_ndone"}, ndone, nd);
    chk({tag, "_rdy_in_wr"}, nrw, 0);
    chk({tag, "_rdy_low"}, nlow, nl);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    rst = 1'b0;
    clear();
    fw = '{16'h1234, 16'hABCD};
    frame("good", 8'h02, 8'hBE, 0);
    fin("good");
    chk_wr("good", 1, NL);
`ifdef LOADER_CHECKSUM_EN
    clear();
    frame("bad", 8'h02, 8'h00, 0);
    @(negedge clk);
    chk("bad_done", done, 0);
    chk("bad_err", err, 1);
    chk("bad_hold", cpu_hold, 1);
    repeat (4) @(negedge clk);
    chk("bad_nwr", wq.size(), 2);
    chk("bad_ndone", ndone, 0);
    chk("bad_err_sticky", err, 1);
`endif
    clear();
    send(8'h11, 0);
    send(8'h22, 2);
    repeat (3) @(negedge clk);
    chk("garbage_nwr", wq.size(), 0);
    chk("garbage_hold", cpu_hold, 0);
    frame("gaps", 8'h02, 8'hBE, 3);
    fin("gaps");
    chk_wr("gaps", 1, NL);
    clear();
    fw.delete();
    for (int i = 0; i < 256; i++) fw.push_back(16'h0101);
    frame("full", 8'h00, 8'h00, 0);
    fin("full");
    chk_wr("full", 1, NL);
    chk("full_addr_wrap", wr_addr, 0);
    clear();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk_reset("midrst");
    rst = 1'b0;
    chk("midrst_nwr", wq.size(), 0);
    clear();
    fw = '{16'h1234, 16'hABCD};
    frame("after_rst", 8'h02, 8'hBE, 1);
    fin("after_rst");
    chk_wr("after_rst", 1, NL);
    clear();
    fw = '{16'h0007};
    frame("one", 8'h01, 8'h07, 0);
    fin("one");
    chk_wr("one", 1, NL);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
